apb_adder_regbank: RTL

- APB slave register bank directly upstream of the adder control FSM.
- Holds the START/op-select control bits and operands A/B; drives them to the control FSM and datapath.
- Captures the sum and carry when the FSM pulses its result-write enable, and clears START on the FSM's clear-start pulse.
- Blocks software writes to control and operand registers while the FSM reports busy.

---
 rtl/apb_adder_regbank.sv | 90 +++++++++
 1 files changed

// File: rtl/apb_adder_regbank.sv
// apb_adder_regbank: APB register bank feeding operands/control to the adder FSM and capturing its result
module apb_adder_regbank #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              ACLK,
  input  logic              ARSTn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic              i_is_busy,
  input  logic              i_en_ctrl_write,
  input  logic              i_rst_start,
  input  logic [DATA_W-1:0] i_sum,
  input  logic              i_carry,
  output logic              o_start,
  output logic              o_op_sel,
  output logic [DATA_W-1:0] o_op_a,
  output logic [DATA_W-1:0] o_op_b
);
  localparam logic [ADDR_W-3:0] CTRL = 0, OPA = 1, OPB = 2, RES = 3, STAT = 4;
  typedef enum logic {IDLE, RESP} state_t;
  state_t state;
  logic [DATA_W-1:0] result, rdata;
  logic [ADDR_W-3:0] off;
  logic done, carry, acc, err, wr_ok, start_set, done_clr;
  logic unused_addr;
  assign off = PADDR[ADDR_W-1:2];
  assign unused_addr = ^PADDR[1:0];
  // Decode the access, classify errors and build the read mux
  always_comb begin
    acc = state == IDLE && PSEL && PENABLE;
    err = off > STAT || (PWRITE && (off == RES || (i_is_busy && (off == CTRL || off == OPA || off == OPB))));
    wr_ok = acc && PWRITE && !err;
    start_set = wr_ok && off == CTRL && PWDATA[0];
    done_clr = start_set || (wr_ok && off == STAT && PWDATA[1]);
    rdata = off == CTRL ? {{(DATA_W-2){1'b0}}, o_op_sel, o_start} :
            off == OPA  ? o_op_a :
            off == OPB  ? o_op_b :
            off == RES  ? result :
            off == STAT ? {{(DATA_W-3){1'b0}}, carry, done, i_is_busy} : '0;
  end
  // APB handshake: one wait cycle, then a single-cycle PREADY response
  always_ff @(posedge ACLK) begin
    if (!ARSTn) begin
      state <= IDLE;
      PRDATA <= '0;
      PREADY <= 1'b0;
      PSLVERR <= 1'b0;
    end else if (state == IDLE) begin
      if (acc) begin
        state <= RESP;
        PREADY <= 1'b1;
        PSLVERR <= err;
        if (!PWRITE) PRDATA <= rdata;
      end
    end else begin
      state <= IDLE;
      PREADY <= 1'b0;
      PSLVERR <= 1'b0;
    end
  end
  // Register bank: software writes, FSM result capture, START clear wins, DONE set wins
  always_ff @(posedge ACLK) begin
    if (!ARSTn) begin
      o_start <= 1'b0;
      o_op_sel <= 1'b0;
      o_op_a <= '0;
      o_op_b <= '0;
      result <= '0;
      carry <= 1'b0;
      done <= 1'b0;
    end else begin
      if (wr_ok && off == CTRL) o_op_sel <= PWDATA[1];
      if (wr_ok && off == OPA) o_op_a <= PWDATA;
      if (wr_ok && off == OPB) o_op_b <= PWDATA;
      o_start <= !i_rst_start && (o_start || start_set);
      if (i_en_ctrl_write) begin
        result <= i_sum;
        carry <= i_carry;
      end
      done <= i_en_ctrl_write || (done && !done_clr);
    end
  end
endmodule
